// File: rtl/mips_reg_dump.sv
// mips_reg_dump: on a rising halted edge, read registers FIRST_REG..LAST_REG and stream them as valid/ready beats.
// Define MIPS_REG_DUMP_CHECKSUM_EN to append a modulo-2^32 sum beat after the register beats.
module mips_reg_dump #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        halted,
  output logic        rd_en,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        done
);
  if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG > 31) begin : g_bad_range
    $error("mips_reg_dump: need 0 <= FIRST_REG <= LAST_REG <= 31");
  end
  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);
  typedef enum logic [2:0] {IDLE, RD, WAIT, SEND, SUM, DONE} state_t;
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d, out_idx_q, out_idx_d;
  logic [31:0] out_data_q, out_data_d;
  logic        halted_q, halted_d, out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic        accept;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif
  assign accept    = out_valid_q && out_ready;
  assign rd_en     = state_q == RD;
  assign rd_addr   = rd_en ? idx_q : 5'd0;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    halted_d    = halted;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE: if (halted && !halted_q) begin
        state_d = RD;
        idx_d   = FIRST;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
        sum_d   = '0;
`endif
      end
      RD: state_d = WAIT;
      WAIT: begin
        out_valid_d = 1'b1;
        out_idx_d   = idx_q;
        out_data_d  = rd_data;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
`else
        out_last_d  = idx_q == LAST;
`endif
        state_d     = SEND;
      end
      SEND: if (accept) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
        sum_d       = sum_q + out_data_q;
`endif
        if (idx_q != LAST) begin
          idx_d   = idx_q + 5'd1;
          state_d = RD;
        end else begin
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
          // the sum beat already includes the register just accepted
          out_valid_d = 1'b1;
          out_idx_d   = 5'd0;
          out_data_d  = sum_q + out_data_q;
          out_last_d  = 1'b1;
          state_d     = SUM;
`else
          state_d     = DONE;
`endif
        end
      end
      SUM: if (accept) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        state_d     = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= FIRST;
      halted_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      halted_q    <= halted_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef MIPS_REG_DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end
endmodule

// File: doc/mips_reg_dump.md
MIPS_REG_DUMP -- requirements
Module: mips_reg_dump

Interface
REQ-001 Parameter FIRST_REG, default 0: first register index dumped.
REQ-002 Parameter LAST_REG, default 31: last register index dumped; FIRST_REG <= LAST_REG <= 31 SHALL hold, else elaboration error.
REQ-003 clk1  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 halted  input  1  processor HALTED flag; a rising edge starts a dump.
REQ-006 rd_en  output  1  register-file read strobe.
REQ-007 rd_addr  output  5  register-file read address.
REQ-008 rd_data  input  32  register-file read data, valid one clk1 cycle after the cycle in which rd_en/rd_addr are presented.
REQ-009 out_valid  output  1  dump beat valid.
REQ-010 out_ready  input  1  sink accepts the beat.
REQ-011 out_idx  output  5  register index of the beat.
REQ-012 out_data  output  32  register value of the beat.
REQ-013 out_last  output  1  final beat of the dump.
REQ-014 busy  output  1  dump in progress (state not IDLE).
REQ-015 done  output  1  one-cycle pulse when the dump completes.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, WAIT, SEND, SUM and DONE; SUM is reachable only when DUMP_CHECKSUM_EN is defined.
REQ-017 Start: a registered copy halted_q SHALL be kept; halted=1 with halted_q=0 at an edge while in IDLE SHALL load idx=FIRST_REG and enter RD.
REQ-018 RD: rd_en=1 and rd_addr=idx; the next edge SHALL enter WAIT.
REQ-019 WAIT: at the next edge rd_data SHALL be captured into out_data, out_idx SHALL be set to idx, out_valid SHALL be set to 1, and the FSM SHALL enter SEND.
REQ-020 Latency: out_valid SHALL rise two edges after the detecting edge; each subsequent beat SHALL take at least 3 cycles.
REQ-021 SEND: out_valid, out_idx, out_data and out_last SHALL stay stable until out_valid and out_ready are both 1 at an edge.
REQ-022 On acceptance with idx<LAST_REG: out_valid SHALL drop, idx SHALL increment by 1, and the FSM SHALL enter RD.
REQ-023 On acceptance with idx==LAST_REG: the FSM SHALL enter DONE, or SUM when DUMP_CHECKSUM_EN is defined.
REQ-024 out_last SHALL be 1 only on the final beat of the dump.
REQ-025 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-026 Edges on halted outside IDLE SHALL be ignored, as SHALL halted falling mid-dump; the dump SHALL always run to completion.
REQ-027 A new dump SHALL require a fresh rising edge on halted while in IDLE.
REQ-028 FIRST_REG==LAST_REG SHALL give a single beat with out_last=1.
REQ-029 idx arithmetic SHALL be 5-bit and SHALL never wrap, because the dump terminates at LAST_REG.

Reset
REQ-030 rst=1 SHALL immediately force the following, even mid-dump, with the in-flight beat discarded: state=IDLE, idx=FIRST_REG, halted_q=0, rd_en=0, rd_addr=0, out_valid=0, out_idx=0, out_data=0, out_last=0, busy=0, done=0, checksum=0.
REQ-031 Because halted_q resets to 0, halted held high when rst is released SHALL start a dump.

Configuration
REQ-032 Macro MIPS_REG_DUMP_CHECKSUM_EN defined: a 32-bit modulo-2^32 sum of all dumped out_data values SHALL be kept.
REQ-033 With the macro, the SUM state SHALL emit one extra beat with out_idx=0, out_data=sum and out_last=1, and the register beats SHALL have out_last=0.
REQ-034 Macro undefined: no sum logic, no SUM state, and out_last SHALL be 1 on the LAST_REG beat.

Verification
REQ-035 Regfile R0..R5={0,10,20,25,30,55}, remaining Rk=k, out_ready=1, halted 0->1 -> 32 beats with idx 0..31 and data as loaded, out_last only on R31, done pulses once.
REQ-036 out_ready held 0 for 10 cycles on the R4 beat -> out_idx=4 and out_data=30 held stable throughout, no beat lost or duplicated.
REQ-037 halted toggled 1->0->1 during a dump -> only one dump of 32 beats, busy continuously 1.
REQ-038 rst pulsed during the R7 beat -> all outputs 0 immediately; with halted still 1 after release, a new dump starts at R0.
REQ-039 FIRST_REG=3, LAST_REG=3, R3=25 -> single beat idx=3, data=25, out_last=1.
REQ-040 With MIPS_REG_DUMP_CHECKSUM_EN, FIRST_REG=0, LAST_REG=5 -> 6 beats with out_last=0, then a sum beat with out_idx=0, out_data=140, out_last=1.
